// File: rtl/digital_trainer_kit.sv
// Two-input logic-gate trainer. Each switch input is synchronized, optionally
// debounced, and the seven basic gate results are registered together.
`timescale 1ns/1ps
module digital_trainer_kit #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    output logic and_out,
    output logic or_out,
    output logic not_a,
    output logic nand_out,
    output logic nor_out,
    output logic xor_out,
    output logic xnor_out
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    // Index 0 is input A, index 1 is input B throughout.
    logic [1:0]                  raw;
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0]                  sync_val;
    logic [1:0]                  acc;

    assign raw = {b, a};

    // Per-input shift chain; stage 0 samples the raw switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i][0] <= raw[i];
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[i][s] <= sync_q[i][s-1];
                end
            end
        end
    end

    // Last stage of each chain is the synchronized value.
    always_comb begin
        sync_val = '0;
        for (int i = 0; i < 2; i++) begin
            sync_val[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_no_db
        assign acc = sync_val;
    end else begin : g_db
        localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES);

        logic [1:0][CntW-1:0] cnt_q, cnt_d;
        logic [1:0]           acc_q, acc_d;

        // Count edges of disagreement; accept on the edge the count would hit the limit.
        always_comb begin
            acc_d = acc_q;
            cnt_d = '0;
            for (int i = 0; i < 2; i++) begin
                if (sync_val[i] != acc_q[i]) begin
                    if (cnt_q[i] + CntW'(1) == CntLast) begin
                        acc_d[i] = sync_val[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
            end
        end

        // Debounce state registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                acc_q <= acc_d;
            end
        end

        assign acc = acc_q;
    end

    // All seven gate results share one register stage so they update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_out  <= 1'b0;
            or_out   <= 1'b0;
            not_a    <= 1'b1;
            nand_out <= 1'b1;
            nor_out  <= 1'b1;
            xor_out  <= 1'b0;
            xnor_out <= 1'b1;
        end else begin
            and_out  <= acc[0] & acc[1];
            or_out   <= acc[0] | acc[1];
            not_a    <= ~acc[0];
            nand_out <= ~(acc[0] & acc[1]);
            nor_out  <= ~(acc[0] | acc[1]);
            xor_out  <= acc[0] ^ acc[1];
            xnor_out <= ~(acc[0] ^ acc[1]);
        end
    end

endmodule

// File: tb/tb_digital_trainer_kit.sv
// Directed bench: reset, truth table, latency, debounce, async reset, invariants.
`timescale 1ns/1ps
module tb_digital_trainer_kit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;

    logic and0, or0, nota0, nand0, nor0, xor0, xnor0;
    logic and1, or1, nota1, nand1, nor1, xor1, xnor1;
    logic [6:0] row0, row1;

    int total = 0;
    int passed = 0;

    // Rows ordered {and, or, not_a, nand, nor, xor, xnor}
    localparam logic [6:0] R00 = 7'b0011101;
    localparam logic [6:0] R01 = 7'b0111010; // a=0 b=1
    localparam logic [6:0] R10 = 7'b0101010; // a=1 b=0
    localparam logic [6:0] R11 = 7'b1100001;

    always #1 clk = ~clk;

    digital_trainer_kit dut0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .and_out(and0), .or_out(or0), .not_a(nota0), .nand_out(nand0),
        .nor_out(nor0), .xor_out(xor0), .xnor_out(xnor0)
    );

    digital_trainer_kit #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .and_out(and1), .or_out(or1), .not_a(nota1), .nand_out(nand1),
        .nor_out(nor1), .xor_out(xor1), .xnor_out(xnor1)
    );

    assign row0 = {and0, or0, nota0, nand0, nor0, xor0, xnor0};
    assign row1 = {and1, or1, nota1, nand1, nor1, xor1, xnor1};

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [1:0] vec [4];
        logic [6:0] exp_row [4];
        vec = '{2'b00, 2'b01, 2'b10, 2'b11}; // {a,b}
        exp_row = '{R00, R01, R10, R11};

        // Reset asserted before any clock edge, inputs high
        a = 1'b1;
        b = 1'b1;
        #0.2 rst_n = 1'b0;
        #0.2;
        check("reset_async_dut0", row0, R00);
        check("reset_async_dut1", row1, R00);
        cycles(3);
        check("reset_held_dut0", row0, R00);
        check("reset_held_dut1", row1, R00);

        // Truth table, 10 ns per vector
        rst_n = 1'b1;
        for (int v = 0; v < 4; v++) begin
            a = vec[v][1];
            b = vec[v][0];
            cycles(5);
            check($sformatf("truth_ab%b", vec[v]), row0, exp_row[v]);
        end

        // Latency with defaults: change just after edge 0, visible after edge 3
        a = 1'b0;
        b = 1'b0;
        cycles(10);
        check("lat_base_dut0", row0, R00);
        check("lat_base_dut1", row1, R00);
        a = 1'b1;
        cycles(2);
        check("lat_edge2_old", row0, R00);
        cycles(1);
        check("lat_edge3_new", row0, R10);

        // Debounce: 2-cycle pulse must be ignored
        a = 1'b0;
        cycles(12);
        check("db_settle", row1, R00);
        a = 1'b1;
        cycles(2);
        a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycles(1);
            check($sformatf("db_pulse_c%0d", i), row1, R00);
        end

        // Debounce: held input accepted after SYNC_STAGES+4+1 = 7 edges
        a = 1'b1;
        cycles(6);
        check("db_hold_edge6_old", row1, R00);
        cycles(1);
        check("db_hold_edge7_new", row1, R10);

        // Async reset mid-run
        a = 1'b1;
        b = 1'b1;
        cycles(10);
        check("mid_pre_dut0", row0, R11);
        check("mid_pre_dut1", row1, R11);
        #0.5 rst_n = 1'b0;
        #0.2;
        check("mid_async_dut0", row0, R00);
        check("mid_async_dut1", row1, R00);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        check("mid_rel_edge2_old", row0, R00);
        cycles(1);
        check("mid_rel_edge3_new", row0, R11);

        // Random toggling: complementary pairs and xor = or & nand every cycle
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check("inv_dut0", {3'b000, nand0, nor0, xnor0, xor0},
                  {3'b000, ~and0, ~or0, ~xor0, or0 & nand0});
            check("inv_dut1", {3'b000, nand1, nor1, xnor1, xor1},
                  {3'b000, ~and1, ~or1, ~xor1, or1 & nand1});
            a = 1'($urandom_range(1, 0));
            b = 1'($urandom_range(1, 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
